execute_scoreboard: RTL and testbench

Register-hazard scoreboard and issue controller for the execute stage. It tracks destination registers of instructions accepted into execute and not yet retired at writeback. It stalls the read/issue handshake when a source or destination would hazard, or when in-flight capacity is exhausted. It sits between decode/read and execute and gates `read_valid` into execute.

---
 rtl/pipeline_pkg.sv | 6 +
 rtl/scoreboard_entry.sv | 44 ++++
 rtl/execute_scoreboard.sv | 96 +++++++++
 tb/tb_execute_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: architectural register index width and type.
package pipeline_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/scoreboard_entry.sv
// One per-register outstanding-write counter: saturating up/down with clear,
// reporting busy (count > 0) and underflow (decrement requested at zero).
module scoreboard_entry #(
  parameter int MAX_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] count,
  output logic       busy,
  output logic       underflow
);
  logic       dec_ok;
  logic       inc_ok;
  logic [1:0] count_next;

  assign busy      = (count != 2'd0);
  assign underflow = dec && (count == 2'd0);
  assign dec_ok    = dec && (count != 2'd0);
  assign inc_ok    = inc && (count != 2'(MAX_COUNT));

  // Next count: a simultaneous valid inc and dec cancel out.
  always_comb begin
    count_next = count;
    case ({inc_ok, dec_ok})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Counter register; clear (flush) overrides inc and dec.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      count <= count_next;
    end
  end
endmodule

// File: rtl/execute_scoreboard.sv
// Register-hazard scoreboard and issue gate for the execute stage.
// Define SCOREBOARD_BYPASS_EN to let RAW checks see a same-cycle retire.
module execute_scoreboard
  import pipeline_pkg::*;
#(
  parameter int MAX_PER_REG = 3,
  parameter int DEPTH       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_req,
  input  reg_idx_t            issue_rd,
  input  reg_idx_t            issue_rs1,
  input  reg_idx_t            issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  output logic                issue_stall,
  output logic                issue_accept,
  input  logic                retire_valid,
  input  reg_idx_t            retire_rd,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [2:0]          inflight_count,
  output logic                error
);
  logic [1:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;
  logic [2:0]          total;
  logic                byp1, byp2;
  logic                raw1, raw2, full, cap;
  logic                track_inc, ret_ok;

  assign cnt[0]       = 2'd0;
  assign underflow[0] = 1'b0;
  assign busy_mask[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      scoreboard_entry #(.MAX_COUNT(MAX_PER_REG)) u_entry (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .inc       (track_inc && (issue_rd == REG_IDX_W'(r))),
        .dec       (retire_valid && (retire_rd == REG_IDX_W'(r))),
        .count     (cnt[r]),
        .busy      (busy_mask[r]),
        .underflow (underflow[r])
      );
    end
  endgenerate

`ifdef SCOREBOARD_BYPASS_EN
  assign byp1 = retire_valid && (retire_rd == issue_rs1);
  assign byp2 = retire_valid && (retire_rd == issue_rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // A bypass hit lowers the effective RAW count by one; full/capacity use raw state.
  assign raw1 = issue_use_rs1 && (issue_rs1 != 5'd0) && (cnt[issue_rs1] > {1'b0, byp1});
  assign raw2 = issue_use_rs2 && (issue_rs2 != 5'd0) && (cnt[issue_rs2] > {1'b0, byp2});
  assign full = (issue_rd != 5'd0) && (cnt[issue_rd] == 2'(MAX_PER_REG));
  assign cap  = (total == 3'(DEPTH));

  assign issue_stall    = issue_req && (raw1 || raw2 || full || cap);
  assign issue_accept   = issue_req && !issue_stall && !flush;
  assign track_inc      = issue_accept && (issue_rd != 5'd0);
  assign ret_ok         = retire_valid && (retire_rd != 5'd0) && !(|underflow) && !flush;
  assign inflight_count = total;

  // Total in-flight count of tracked (rd != 0) instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      total <= 3'd0;
    end else if (flush) begin
      total <= 3'd0;
    end else begin
      case ({track_inc, ret_ok})
        2'b10:   total <= total + 3'd1;
        2'b01:   total <= total - 3'd1;
        default: total <= total;
      endcase
    end
  end

  // One-cycle error pulse after a retire against an idle register.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= !flush && (|underflow);
    end
  end
endmodule

// File: tb/tb_execute_scoreboard.sv
// Self-checking bench for execute_scoreboard: directed plan scenarios plus a
// randomized run checked against a per-register counting model.
module tb_execute_scoreboard;
  logic        clk = 1'b0;
  logic        reset, flush, issue_req;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, retire_rd;
  logic        issue_use_rs1, issue_use_rs2, retire_valid;
  logic        issue_stall, issue_accept, error;
  logic [31:0] busy_mask;
  logic [2:0]  inflight_count;
  int          n_cmp = 0;
  int          n_bad = 0;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  execute_scoreboard #(.MAX_PER_REG(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_req(issue_req),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_stall(issue_stall), .issue_accept(issue_accept),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .busy_mask(busy_mask), .inflight_count(inflight_count), .error(error)
  );

  task automatic idle();
    reset = 1'b0; flush = 1'b0; issue_req = 1'b0; issue_rd = 5'd0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
    retire_valid = 1'b0; retire_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_req = 1'b1; issue_rd = rd;
  endtask

  task automatic retire(input logic [4:0] rd);
    retire_valid = 1'b1; retire_rd = rd;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL reset_busy got %h exp 0", busy_mask); end
    n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL reset_inflight got %0d exp 0", inflight_count); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b exp 0", error); end
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", issue_stall); end
  endtask

  task automatic test_basic();
    idle(); issue(5'd5); #1;
    n_cmp++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL basic_accept got %b exp 1", issue_accept); end
    tick(); idle(); #1;
    n_cmp++; if (busy_mask !== 32'h20) begin n_bad++; $display("FAIL basic_busy got %h exp 00000020", busy_mask); end
    n_cmp++; if (inflight_count !== 3'd1) begin n_bad++; $display("FAIL basic_inflight got %0d exp 1", inflight_count); end
  endtask

  task automatic test_raw();
    idle(); issue(5'd6); issue_rs1 = 5'd5; issue_use_rs1 = 1'b1; #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall got %b exp 1", issue_stall); end
    retire(5'd5); #1;
    n_cmp++; if (issue_accept !== BYP) begin n_bad++; $display("FAIL raw_retire_cycle_accept got %b exp %b", issue_accept, BYP); end
    tick(); retire_valid = 1'b0;
    if (!BYP) begin
      #1;
      n_cmp++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL raw_next_accept got %b exp 1", issue_accept); end
      n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL raw_busy_cleared got %h exp 0", busy_mask); end
      tick();
    end
    idle(); #1;
    n_cmp++; if (busy_mask !== 32'h40) begin n_bad++; $display("FAIL raw_busy_after got %h exp 00000040", busy_mask); end
    retire(5'd6); tick(); idle(); #1;
    n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL raw_drain got %0d exp 0", inflight_count); end
  endtask

  task automatic test_rd_zero();
    idle(); issue(5'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL rd0_accept got %b exp 1", issue_accept); end
      tick();
    end
    idle(); #1;
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL rd0_busy got %h exp 0", busy_mask); end
    n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL rd0_inflight got %0d exp 0", inflight_count); end
    issue(5'd3); tick(); idle();
    issue(5'd0); issue_rs1 = 5'd0; issue_use_rs1 = 1'b1; issue_rs2 = 5'd3; issue_use_rs2 = 1'b0; #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL rs0_stall got %b exp 0", issue_stall); end
    idle(); retire(5'd3); tick(); idle();
  endtask

  task automatic test_per_reg_full();
    idle(); issue(5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL full_accept%0d got %b exp 1", i, issue_accept); end
      tick();
    end
    #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got %b exp 1", issue_stall); end
    retire(5'd7); #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL full_stall_on_retire got %b exp 1", issue_stall); end
    tick(); retire_valid = 1'b0; #1;
    n_cmp++; if (busy_mask[7] !== 1'b1) begin n_bad++; $display("FAIL full_busy7 got %b exp 1", busy_mask[7]); end
    n_cmp++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL full_late_accept got %b exp 1", issue_accept); end
    tick(); idle(); #1;
    n_cmp++; if (inflight_count !== 3'd3) begin n_bad++; $display("FAIL full_inflight got %0d exp 3", inflight_count); end
    retire(5'd7); tick(); tick(); tick(); idle(); #1;
    n_cmp++; if (inflight_count !== 3'd0 || busy_mask !== 32'h0) begin
      n_bad++; $display("FAIL full_drain got %0d/%h exp 0/0", inflight_count, busy_mask); end
  endtask

  task automatic test_capacity();
    idle();
    for (int i = 1; i <= 4; i++) begin issue(5'(i)); tick(); end
    issue(5'd9); #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL cap_stall got %b exp 1", issue_stall); end
    retire(5'd1); #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL cap_stall_on_retire got %b exp 1", issue_stall); end
    tick(); retire_valid = 1'b0; #1;
    n_cmp++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL cap_late_accept got %b exp 1", issue_accept); end
    tick(); idle(); #1;
    n_cmp++; if (inflight_count !== 3'd4 || busy_mask !== 32'h21C) begin
      n_bad++; $display("FAIL cap_state got %0d/%h exp 4/0000021c", inflight_count, busy_mask); end
    retire(5'd2); tick(); retire(5'd3); tick(); retire(5'd4); tick(); retire(5'd9); tick(); idle();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 1; i <= 3; i++) begin issue(5'(i)); tick(); end
    issue(5'd4); flush = 1'b1; retire(5'd1); #1;
    n_cmp++; if (issue_accept !== 1'b0) begin n_bad++; $display("FAIL flush_accept got %b exp 0", issue_accept); end
    tick(); idle(); #1;
    n_cmp++; if (inflight_count !== 3'd0 || busy_mask !== 32'h0) begin
      n_bad++; $display("FAIL flush_clear got %0d/%h exp 0/0", inflight_count, busy_mask); end
    retire(5'd2); tick(); idle(); #1;
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL flush_underflow_err got %b exp 1", error); end
    n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL flush_underflow_cnt got %0d exp 0", inflight_count); end
    tick(); #1;
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL err_pulse_len got %b exp 0", error); end
  endtask

  task automatic test_reset_mid();
    idle(); issue(5'd3); tick(); issue(5'd4); retire(5'd3); reset = 1'b1; tick(); idle(); #1;
    n_cmp++; if (inflight_count !== 3'd0 || busy_mask !== 32'h0 || error !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got %0d/%h/%b exp 0/0/0", inflight_count, busy_mask, error); end
  endtask

  task automatic test_random();
    int  m_cnt[32];
    int  m_tot;
    bit  m_err;
    bit  exp_stall, exp_acc, h;
    logic [31:0] exp_busy;
    idle(); reset = 1'b1; tick(); idle();
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_tot = 0; m_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      issue_req = ($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom_range(0, 6));
      issue_rs1 = 5'($urandom_range(0, 6));
      issue_rs2 = 5'($urandom_range(0, 6));
      issue_use_rs1 = 1'($urandom_range(0, 1));
      issue_use_rs2 = 1'($urandom_range(0, 1));
      retire_valid = ($urandom_range(0, 2) != 0);
      retire_rd = 5'($urandom_range(0, 6));
      h = 1'b0;
      if (issue_use_rs1 && issue_rs1 != 5'd0 &&
          m_cnt[issue_rs1] - ((BYP && retire_valid && retire_rd == issue_rs1) ? 1 : 0) > 0) h = 1'b1;
      if (issue_use_rs2 && issue_rs2 != 5'd0 &&
          m_cnt[issue_rs2] - ((BYP && retire_valid && retire_rd == issue_rs2) ? 1 : 0) > 0) h = 1'b1;
      if (issue_rd != 5'd0 && m_cnt[issue_rd] == 3) h = 1'b1;
      if (m_tot == 4) h = 1'b1;
      exp_stall = issue_req && h;
      exp_acc = issue_req && !h && !flush;
      #1;
      n_cmp++; if (issue_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, issue_stall, exp_stall); end
      n_cmp++; if (issue_accept !== exp_acc) begin n_bad++; $display("FAIL rnd_accept c=%0d got %b exp %b", c, issue_accept, exp_acc); end
      if (reset || flush) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_tot = 0; m_err = 1'b0;
      end else begin
        m_err = retire_valid && retire_rd != 5'd0 && m_cnt[retire_rd] == 0;
        if (exp_acc && issue_rd != 5'd0) begin m_cnt[issue_rd]++; m_tot++; end
        if (retire_valid && retire_rd != 5'd0 && !m_err) begin m_cnt[retire_rd]--; m_tot--; end
      end
      tick();
      exp_busy = 32'h0;
      for (int k = 1; k < 32; k++) exp_busy[k] = (m_cnt[k] > 0);
      n_cmp++; if (busy_mask !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d got %h exp %h", c, busy_mask, exp_busy); end
      n_cmp++; if (inflight_count !== 3'(m_tot)) begin n_bad++; $display("FAIL rnd_inflight c=%0d got %0d exp %0d", c, inflight_count, m_tot); end
      n_cmp++; if (error !== m_err) begin n_bad++; $display("FAIL rnd_error c=%0d got %b exp %b", c, error, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_raw();
    test_rd_zero();
    test_per_reg_full();
    test_capacity();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
